// File: rtl/recv_uart_if.sv
// recv_uart_if: caller-side handshake and serial line of the UART receiver.
//   start       - arm request from the caller (pulse)
//   UART_RXD    - serial receive line, idle high
//   finish      - one-cycle pulse when a frame completes
//   return_val  - received byte, held until the next frame completes
//   frame_error - qualifies return_val on finish (bad stop / parity)
// master: the caller/line driver; slave: the receiver.
interface recv_uart_if;
  logic       start;
  logic       UART_RXD;
  logic       finish;
  logic [7:0] return_val;
  logic       frame_error;

  modport master (
    output start, UART_RXD,
    input  finish, return_val, frame_error
  );

  modport slave (
    input  start, UART_RXD,
    output finish, return_val, frame_error
  );
endinterface

// File: rtl/recv_uart.sv
// recv_uart: armed single-byte UART receiver, 8N1 LSB first.
// The caller pulses start; the block waits for one frame on UART_RXD and
// returns the byte with a one-cycle finish pulse.
// Ports:
//   clk   - system clock, posedge
//   reset - asynchronous, active-low
//   bus   - recv_uart_if.slave (start, UART_RXD, finish, return_val,
//           frame_error)
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit (4..65535)
//   HALF_BIT     - falling edge to start-bit centre offset
// Build option: define RECV_UART_PARITY_EN for 8E1 framing; frame_error then
// also flags an even-parity mismatch.
module recv_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        clk,
  input  logic        reset,
  recv_uart_if.slave  bus
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef RECV_UART_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_rxd_s;
  logic        r_prev;
  logic [15:0] r_cnt;
  logic [2:0]  r_dcnt;
  logic [7:0]  r_shift;
  logic        r_finish;
  logic [7:0]  r_ret;
  logic        r_ferr;
`ifdef RECV_UART_PARITY_EN
  logic        r_par;
`endif
  logic        w_fall;
  logic        w_bit_end;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.UART_RXD;
      r_rxd_s <= r_sync1;
      r_prev  <= r_rxd_s;
    end
  end

  assign w_fall    = r_prev & ~r_rxd_s;
  assign w_bit_end = (r_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_shift  <= '0;
      r_finish <= 1'b0;
      r_ret    <= '0;
      r_ferr   <= 1'b0;
`ifdef RECV_UART_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!r_rxd_s) begin
              r_dcnt  <= '0;
              r_state <= S_DATA;
            end else begin
              r_state <= S_WAIT;  // start bit gone at its centre: glitch
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {r_rxd_s, r_shift[7:1]};
            r_dcnt  <= r_dcnt + 3'd1;
            if (r_dcnt == 3'd7) begin
`ifdef RECV_UART_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`ifdef RECV_UART_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_par   <= r_rxd_s;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_ret    <= r_shift;
`ifdef RECV_UART_PARITY_EN
            r_ferr   <= ~r_rxd_s | (r_par ^ (^r_shift));
`else
            r_ferr   <= ~r_rxd_s;
`endif
            r_finish <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.finish      = r_finish;
  assign bus.return_val  = r_ret;
  assign bus.frame_error = r_ferr;

endmodule

// File: tb/tb_recv_uart.sv
// tb_recv_uart: self-checking bench for recv_uart.
// A frame-level model predicts, for every frame sent while armed, the cycle
// finish must pulse, the byte and the frame_error flag; a compare process
// checks finish and return_val every cycle against it.
module tb_recv_uart;

  localparam int unsigned CPB  = 434;
  localparam int unsigned HALF = CPB / 2;
`ifdef RECV_UART_PARITY_EN
  localparam bit          PAR_ON = 1'b1;
  localparam int unsigned LAT_LIT = 4560;
`else
  localparam bit          PAR_ON = 1'b0;
  localparam int unsigned LAT_LIT = 4126;
`endif
  // Pin falling edge to finish: sync + half bit + data/parity/stop bits + 1.
  localparam int unsigned LAT = 3 + HALF + (9 + (PAR_ON ? 1 : 0)) * CPB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  recv_uart_if bus();

  recv_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned at;
    logic [7:0]  data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  m_val = 8'h00;
  bit          armed = 1'b0;
  int unsigned fin_cnt = 0;
  int unsigned last_fin = 0;
  exp_t        cx;
  logic        cfin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Every-cycle compare against the frame-level model.
  always @(negedge clk) begin
    cfin = 1'b0;
    if (q.size() > 0 && q[0].at == cyc) begin
      cx    = q.pop_front();
      cfin  = 1'b1;
      m_val = cx.data;
    end
    if (bus.finish === 1'b1) begin
      fin_cnt++;
      last_fin = cyc;
    end
    chk("finish", {31'd0, bus.finish}, {31'd0, cfin});
    chk("return_val", {24'd0, bus.return_val}, {24'd0, m_val});
    if (cfin) chk("frame_error", {31'd0, bus.frame_error}, {31'd0, cx.err});
  end

  task automatic hold(input logic v, input int unsigned n);
    bus.UART_RXD = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    @(posedge clk); #1;
    bus.start = 1'b1;
    armed = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            output int unsigned e);
    exp_t x;
    @(posedge clk); #1;
    e = cyc;
    if (armed) begin
      x.at   = cyc + LAT;
      x.data = d;
      x.err  = !stop || (PAR_ON && (par != ^d));
      q.push_back(x);
      armed = 1'b0;
    end
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    if (PAR_ON) hold(par, CPB);
    hold(stop, CPB);
    hold(1'b1, 40);
  endtask

  int unsigned e;
  int unsigned f0;
  logic [7:0]  rd;

  initial begin
    bus.start    = 1'b0;
    bus.UART_RXD = 1'b1;
    reset        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_finish", {31'd0, bus.finish}, 32'd0);
    chk("rst_return_val", {24'd0, bus.return_val}, 32'h00);
    chk("rst_frame_error", {31'd0, bus.frame_error}, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 8'hA5 with exact latency
    pulse_start();
    f0 = fin_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, e);
    chk("a5_val", {24'd0, bus.return_val}, 32'hA5);
    chk("a5_err", {31'd0, bus.frame_error}, 32'd0);
    chk("a5_count", fin_cnt - f0, 32'd1);
    chk("a5_latency", last_fin - e, LAT_LIT);

    // glitch shorter than half a bit, then 8'h3C
    pulse_start();
    f0 = fin_cnt;
    @(posedge clk); #1;
    hold(1'b0, 100);
    hold(1'b1, 300);
    chk("glitch_nofinish", fin_cnt - f0, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, e);
    chk("3c_val", {24'd0, bus.return_val}, 32'h3C);
    chk("3c_count", fin_cnt - f0, 32'd1);

    // bad stop bit, then clean 8'h00
    pulse_start();
    send_frame(8'hFF, 1'b0, 1'b0, e);
    chk("ff_val", {24'd0, bus.return_val}, 32'hFF);
    chk("ff_err", {31'd0, bus.frame_error}, 32'd1);
    pulse_start();
    send_frame(8'h00, 1'b1, 1'b0, e);
    chk("00_val", {24'd0, bus.return_val}, 32'h00);
    chk("00_err", {31'd0, bus.frame_error}, 32'd0);

    // unarmed byte is dropped
    f0 = fin_cnt;
    send_frame(8'h55, 1'b1, 1'b0, e);
    chk("unarmed_count", fin_cnt - f0, 32'd0);
    chk("unarmed_val", {24'd0, bus.return_val}, 32'h00);
    pulse_start();
    send_frame(8'h12, 1'b1, 1'b0, e);
    chk("12_val", {24'd0, bus.return_val}, 32'h12);

    // reset during data bit 4
    pulse_start();
    f0 = fin_cnt;
    fork
      send_frame(8'hC3, 1'b1, 1'b0, e);
      begin
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_val = 8'h00;
        armed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
      end
    join
    chk("abort_count", fin_cnt - f0, 32'd0);
    chk("abort_val", {24'd0, bus.return_val}, 32'h00);
    pulse_start();
    send_frame(8'hC3, 1'b1, 1'b0, e);
    chk("c3_val", {24'd0, bus.return_val}, 32'hC3);
    chk("c3_count", fin_cnt - f0, 32'd1);

    // parity handling (8N1 build ignores the parity argument)
    pulse_start();
    send_frame(8'h07, 1'b1, 1'b1, e);
    chk("07_p1_err", {31'd0, bus.frame_error}, 32'd0);
    pulse_start();
    send_frame(8'h07, 1'b1, 1'b0, e);
    chk("07_p0_err", {31'd0, bus.frame_error}, PAR_ON ? 32'd1 : 32'd0);

    // randomized frames
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 3) != 0) pulse_start();
      rd = 8'($urandom);
      send_frame(rd, $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), e);
      repeat ($urandom_range(1, 30)) @(posedge clk);
      #1;
    end

    repeat (20) @(posedge clk);
    #1;
    chk("model_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
